// File: rtl/sha256_digest_uart_tx.sv
// sha256_digest_uart_tx
//   Serializes one 256-bit SHA-256 digest onto an 8N1 UART line. With HEX_ASCII=1
//   the digest goes out as 64 lowercase hex characters followed by CR LF (66 bytes).
//   With HEX_ASCII=0 it goes out as 32 raw bytes. Either way the most significant
//   nibble or byte is sent first.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   digest        digest to send, word 0 in [255:224]
//   digest_valid  digest offered this cycle
//   digest_ready  idle and able to take a digest
//   busy          from acceptance until the final stop bit completes
//   done          one-cycle pulse at the end of the final stop bit
//   uart_tx       serial line, idles high, driven from a flop
//
// State table
//   IDLE   | line high; accept a digest, then spend one load cycle before START
//   START  | start bit (0)
//   DATA   | 8 data bits, LSB first
//   STOP   | stop bit (1); then the next byte's START, or FINISH
//   FINISH | done pulse; busy drops and ready rises on the exit edge
module sha256_digest_uart_tx #(
  parameter int CLK_HZ    = 27000000,
  parameter int BAUD      = 115200,
  parameter bit HEX_ASCII = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] digest,
  input  logic         digest_valid,
  output logic         digest_ready,
  output logic         busy,
  output logic         done,
  output logic         uart_tx
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int NBYTES       = HEX_ASCII ? 66 : 32;
  localparam int STEP         = HEX_ASCII ? 4 : 8;
  localparam int TMR_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W       = $clog2(NBYTES);

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, FINISH} state_t;

  state_t              state;
  logic [TMR_W-1:0]    tmr;
  logic [2:0]          bit_idx;
  logic [BYTE_W-1:0]   byte_idx;
  logic [7:0]          shreg;
  logic [255:0]        dreg;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h57 + {4'h0, nib};
  endfunction

  // The unsent part of the digest is kept left-aligned, so the next nibble or
  // byte always sits in the top 8 bits. Bytes 64/65 in hex mode are CR LF.
  function automatic logic [7:0] byte_at(input logic [BYTE_W-1:0] idx,
                                         input logic [7:0] top);
    logic [7:0] b;
    b = top;
    if (HEX_ASCII) begin
      if (int'(idx) == 64)      b = 8'h0D;
      else if (int'(idx) == 65) b = 8'h0A;
      else                      b = hex_char(top[7:4]);
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      tmr          <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      shreg        <= '0;
      dreg         <= '0;
      uart_tx      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      digest_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (busy) begin
            // load cycle done; the start bit begins on this edge
            state   <= START;
            uart_tx <= 1'b0;
            tmr     <= '0;
          end else if (digest_ready && digest_valid) begin
            busy         <= 1'b1;
            digest_ready <= 1'b0;
            byte_idx     <= '0;
            shreg        <= byte_at('0, digest[255:248]);
            dreg         <= digest << STEP;
          end else begin
            digest_ready <= 1'b1;
          end
        end

        START: begin
          if (tmr == TMR_LAST) begin
            tmr     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            uart_tx <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        DATA: begin
          if (tmr == TMR_LAST) begin
            tmr <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              uart_tx <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        STOP: begin
          if (tmr == TMR_LAST) begin
            tmr <= '0;
            if (byte_idx == BYTE_LAST) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              shreg    <= byte_at(byte_idx + 1'b1, dreg[255:248]);
              dreg     <= dreg << STEP;
              state    <= START;
              uart_tx  <= 1'b0;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        FINISH: begin
          done         <= 1'b0;
          busy         <= 1'b0;
          digest_ready <= 1'b1;
          state        <= IDLE;
        end

        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
